ir_nec_ctrl: RTL

- Sequences the IR-receiver-to-LED path: decodes NEC-protocol frames from the demodulated IR receiver pin and drives the LED.
- Replaces the direct pin-to-LED pass-through with a synchronised, timed state machine.
- Outputs are a decoded address/command pair, a repeat-code strobe and a registered LED that toggles on a matching command.
- Sits between the IR input pad buffer and the LED output pad buffer.

---
 rtl/ir_nec_pkg.sv | 37 +++
 rtl/ir_pulse_timer.sv | 61 ++++++
 rtl/ir_nec_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - NEC decoder states, tick windows and helpers
package ir_nec_pkg;

  localparam int DUR_W = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD_L = 3'd1,
    LEAD_H = 3'd2,
    BIT_L  = 3'd3,
    BIT_H  = 3'd4,
    STOP_L = 3'd5,
    RPT_L  = 3'd6
  } state_t;

  // Pulse-width windows in 10 us ticks, inclusive at both ends
  localparam logic [DUR_W-1:0] LEAD_L_MIN = 11'd800;
  localparam logic [DUR_W-1:0] LEAD_L_MAX = 11'd1000;
  localparam logic [DUR_W-1:0] LEAD_H_MIN = 11'd400;
  localparam logic [DUR_W-1:0] LEAD_H_MAX = 11'd500;
  localparam logic [DUR_W-1:0] RPT_H_MIN  = 11'd180;
  localparam logic [DUR_W-1:0] RPT_H_MAX  = 11'd270;
  localparam logic [DUR_W-1:0] BURST_MIN  = 11'd40;
  localparam logic [DUR_W-1:0] BURST_MAX  = 11'd72;
  localparam logic [DUR_W-1:0] SP0_MIN    = 11'd40;
  localparam logic [DUR_W-1:0] SP0_MAX    = 11'd72;
  localparam logic [DUR_W-1:0] SP1_MIN    = 11'd140;
  localparam logic [DUR_W-1:0] SP1_MAX    = 11'd200;
  localparam logic [DUR_W-1:0] TIMEOUT    = 11'd1000;

  function automatic logic in_win(input logic [DUR_W-1:0] d,
                                  input logic [DUR_W-1:0] lo,
                                  input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// rtl/ir_pulse_timer.sv - IR pin synchroniser, edge detect and pulse duration counter
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int TICK_DIV = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir,
  output logic             rise,
  output logic             fall,
  output logic [DUR_W-1:0] dur
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic          ir_m;
  logic          ir_s;
  logic          ir_d;
  logic [PW-1:0] pre;
  logic          tick;

  // Sync flops reset to the idle-high level so reset release never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_m <= 1'b1;
      ir_s <= 1'b1;
      ir_d <= 1'b1;
    end else begin
      ir_m <= ir;
      ir_s <= ir_m;
      ir_d <= ir_s;
    end
  end

  assign fall = ~ir_s & ir_d;
  assign rise = ir_s & ~ir_d;
  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur <= '0;
    end else if (rise || fall) begin
      dur <= '0;
    end else if (tick && (dur != {DUR_W{1'b1}})) begin
      dur <= dur + 1'b1;
    end
  end

endmodule

// File: rtl/ir_nec_ctrl.sv
// rtl/ir_nec_ctrl.sv - NEC frame decoder driving a command-toggled LED
module ir_nec_ctrl
  import ir_nec_pkg::*;
#(
  parameter int         TICK_DIV = 120,
  parameter logic [7:0] LED_CMD  = 8'h45,
  parameter logic [7:0] LED_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir,
  output logic       frame_vld,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       rpt,
  output logic       err,
  output logic       led
);

  logic             rise;
  logic             fall;
  logic [DUR_W-1:0] dur;

  state_t           state;
  state_t           state_n;
  logic [4:0]       bitcnt;
  logic [4:0]       bitcnt_n;
  logic [31:0]      sr;
  logic [31:0]      sr_n;
  logic             have_frame;
  logic             frame_ok;
  logic             rpt_n;
  logic             err_n;
  logic             burst_ok;
  logic             sp0_ok;
  logic             sp1_ok;
  logic             inv_ok;

  ir_pulse_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .ir   (ir),
    .rise (rise),
    .fall (fall),
    .dur  (dur)
  );

  assign burst_ok = in_win(dur, BURST_MIN, BURST_MAX);
  assign sp0_ok   = in_win(dur, SP0_MIN, SP0_MAX);
  assign sp1_ok   = in_win(dur, SP1_MIN, SP1_MAX);
  assign inv_ok   = (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    sr_n     = sr;
    frame_ok = 1'b0;
    rpt_n    = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) state_n = LEAD_L;
      end
      LEAD_L: begin
        // A short or long leader is treated as noise, not as a broken frame
        if (rise) state_n = in_win(dur, LEAD_L_MIN, LEAD_L_MAX) ? LEAD_H : IDLE;
      end
      LEAD_H: begin
        if (fall) begin
          if (in_win(dur, LEAD_H_MIN, LEAD_H_MAX)) begin
            state_n  = BIT_L;
            bitcnt_n = 5'd0;
          end else if (in_win(dur, RPT_H_MIN, RPT_H_MAX)) begin
            state_n = RPT_L;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      BIT_L: begin
        if (rise) begin
          state_n = burst_ok ? BIT_H : IDLE;
          err_n   = ~burst_ok;
        end
      end
      BIT_H: begin
        if (fall) begin
          if (sp0_ok || sp1_ok) begin
            sr_n     = {sp1_ok, sr[31:1]};
            bitcnt_n = bitcnt + 5'd1;
            state_n  = (bitcnt == 5'd31) ? STOP_L : BIT_L;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      STOP_L: begin
        if (rise) begin
          state_n  = IDLE;
          frame_ok = burst_ok && inv_ok;
          err_n    = ~(burst_ok && inv_ok);
        end
      end
      RPT_L: begin
        if (rise) begin
          state_n = IDLE;
          rpt_n   = burst_ok && have_frame;
          err_n   = ~burst_ok;
        end
      end
      default: state_n = IDLE;
    endcase
    if ((state != IDLE) && !(rise || fall) && (dur > TIMEOUT)) begin
      state_n = IDLE;
      err_n   = (state != LEAD_L);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= 5'd0;
      sr         <= 32'd0;
      have_frame <= 1'b0;
      frame_vld  <= 1'b0;
      rpt        <= 1'b0;
      err        <= 1'b0;
      addr       <= 8'd0;
      cmd        <= 8'd0;
      led        <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      sr        <= sr_n;
      frame_vld <= frame_ok;
      rpt       <= rpt_n;
      err       <= err_n;
      if (frame_ok) begin
        addr       <= sr[7:0];
        cmd        <= sr[23:16];
        have_frame <= 1'b1;
        if ((sr[7:0] == LED_ADDR) && (sr[23:16] == LED_CMD)) led <= ~led;
      end
    end
  end

endmodule
